// File: rtl/adc_spi_responder.sv
// adc_spi_responder: SPI mode-0 slave that stands in for a 4-channel 12-bit ADC.
// SCK, CS_n and MOSI are oversampled on clk_100mhz. The master's channel command
// selects the sample returned in the *next* frame. MISO carries {ch, 2'b00, sample}.
module adc_spi_responder #(
  parameter int         SYNC_STAGES = 2,
  parameter logic [1:0] DEFAULT_CH  = 2'd0
) (
  input  logic        clk_100mhz,
  input  logic        rst_n,
  input  logic        spi_sck,
  input  logic        spi_cs_n,
  input  logic        spi_mosi,
  output logic        spi_miso,
  output logic        spi_miso_oe,
  input  logic [11:0] ch0_data,
  input  logic [11:0] ch1_data,
  input  logic [11:0] ch2_data,
  input  logic [11:0] ch3_data,
  output logic        sample_strobe,
  output logic [1:0]  cur_ch,
  output logic        frame_done,
  output logic        frame_err,
  output logic [15:0] frame_count
);

  // Never fewer than two synchronizer flops, whatever the parameter says.
  localparam int SYNC_N = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_t;

  logic [SYNC_N-1:0] sck_sync_r;
  logic [SYNC_N-1:0] cs_sync_r;
  logic [SYNC_N-1:0] mosi_sync_r;
  logic              sck_prev_r;
  logic              cs_prev_r;

  logic              sck_s;
  logic              cs_s;
  logic              mosi_s;
  logic              sck_rise_s;
  logic              sck_fall_s;
  logic              cs_rise_s;
  logic              cs_fall_s;
  logic [11:0]       sample_s;

  state_t            state_r;
  logic [15:0]       tx_r;
  logic [14:0]       rx_r;
  logic [4:0]        bit_cnt_r;

  // Synchronizer chains plus one edge-detect flop for SCK and CS.
  // CS resets high so leaving reset never looks like a frame start.
  always_ff @(posedge clk_100mhz or negedge rst_n) begin
    if (!rst_n) begin
      sck_sync_r  <= {SYNC_N{1'b0}};
      cs_sync_r   <= {SYNC_N{1'b1}};
      mosi_sync_r <= {SYNC_N{1'b0}};
      sck_prev_r  <= 1'b0;
      cs_prev_r   <= 1'b1;
    end else begin
      sck_sync_r  <= {sck_sync_r[SYNC_N-2:0], spi_sck};
      cs_sync_r   <= {cs_sync_r[SYNC_N-2:0], spi_cs_n};
      mosi_sync_r <= {mosi_sync_r[SYNC_N-2:0], spi_mosi};
      sck_prev_r  <= sck_sync_r[SYNC_N-1];
      cs_prev_r   <= cs_sync_r[SYNC_N-1];
    end
  end

  // Edge decode from the synchronized pins.
  always_comb begin
    sck_s      = sck_sync_r[SYNC_N-1];
    cs_s       = cs_sync_r[SYNC_N-1];
    mosi_s     = mosi_sync_r[SYNC_N-1];
    sck_rise_s = sck_s & ~sck_prev_r;
    sck_fall_s = ~sck_s & sck_prev_r;
    cs_rise_s  = cs_s & ~cs_prev_r;
    cs_fall_s  = ~cs_s & cs_prev_r;
  end

  // Select the live sample for the channel the next frame will return.
  always_comb begin
    sample_s = 12'h000;
    case (cur_ch)
      2'd0:    sample_s = ch0_data;
      2'd1:    sample_s = ch1_data;
      2'd2:    sample_s = ch2_data;
      2'd3:    sample_s = ch3_data;
      default: sample_s = 12'h000;
    endcase
  end

  // Frame FSM: latch sample on CS fall, shift on SCK edges, close on CS rise.
  // tx shifts in zeros, so bits beyond the 16th drive MISO low.
  // A CS rise takes priority over any SCK edge decoded in the same cycle.
  always_ff @(posedge clk_100mhz or negedge rst_n) begin
    if (!rst_n) begin
      state_r       <= ST_IDLE;
      tx_r          <= 16'h0000;
      rx_r          <= 15'h0000;
      bit_cnt_r     <= 5'd0;
      spi_miso      <= 1'b0;
      spi_miso_oe   <= 1'b0;
      sample_strobe <= 1'b0;
      frame_done    <= 1'b0;
      frame_err     <= 1'b0;
      frame_count   <= 16'h0000;
      cur_ch        <= DEFAULT_CH;
    end else begin
      sample_strobe <= 1'b0;
      frame_done    <= 1'b0;
      frame_err     <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          spi_miso    <= 1'b0;
          spi_miso_oe <= 1'b0;
          if (cs_fall_s) begin
            tx_r          <= {cur_ch, 2'b00, sample_s};
            rx_r          <= 15'h0000;
            bit_cnt_r     <= 5'd0;
            sample_strobe <= 1'b1;
            spi_miso_oe   <= 1'b1;
            state_r       <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          spi_miso    <= tx_r[15];
          spi_miso_oe <= 1'b1;
          if (cs_rise_s) begin
            spi_miso    <= 1'b0;
            spi_miso_oe <= 1'b0;
            frame_err   <= (bit_cnt_r != 5'd16);
            state_r     <= ST_IDLE;
          end else if (sck_rise_s) begin
            if (bit_cnt_r < 5'd16) begin
              rx_r <= {rx_r[13:0], mosi_s};
            end
            if (bit_cnt_r != 5'd31) begin
              bit_cnt_r <= bit_cnt_r + 5'd1;
            end
            // 16th rise: rx_r[14] is the start bit, rx_r[13:12] the channel.
            if (bit_cnt_r == 5'd15) begin
              frame_done  <= 1'b1;
              frame_count <= frame_count + 16'd1;
              if (rx_r[14]) begin
                cur_ch <= rx_r[13:12];
              end
            end
          end else if (sck_fall_s) begin
            tx_r <= {tx_r[14:0], 1'b0};
          end
        end
        default: begin
          state_r     <= ST_IDLE;
          spi_miso    <= 1'b0;
          spi_miso_oe <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_adc_spi_responder.sv
// Directed bench for adc_spi_responder: bit-bangs SPI mode-0 frames and
// compares MISO words, pulse counts and status against hand-computed values.
module tb_adc_spi_responder;

  localparam int HALF = 8;  // SCK half period in clk_100mhz cycles

  logic        clk_100mhz = 1'b0;
  logic        rst_n      = 1'b0;
  logic        spi_sck    = 1'b0;
  logic        spi_cs_n   = 1'b1;
  logic        spi_mosi   = 1'b0;
  logic        spi_miso;
  logic        spi_miso_oe;
  logic [11:0] ch0_data   = 12'h000;
  logic [11:0] ch1_data   = 12'h000;
  logic [11:0] ch2_data   = 12'h000;
  logic [11:0] ch3_data   = 12'h000;
  logic        sample_strobe;
  logic [1:0]  cur_ch;
  logic        frame_done;
  logic        frame_err;
  logic [15:0] frame_count;

  int n_checks = 0;
  int n_bad    = 0;
  int done_cnt = 0;
  int err_cnt  = 0;
  int strb_cnt = 0;

  adc_spi_responder dut (
    .clk_100mhz    (clk_100mhz),
    .rst_n         (rst_n),
    .spi_sck       (spi_sck),
    .spi_cs_n      (spi_cs_n),
    .spi_mosi      (spi_mosi),
    .spi_miso      (spi_miso),
    .spi_miso_oe   (spi_miso_oe),
    .ch0_data      (ch0_data),
    .ch1_data      (ch1_data),
    .ch2_data      (ch2_data),
    .ch3_data      (ch3_data),
    .sample_strobe (sample_strobe),
    .cur_ch        (cur_ch),
    .frame_done    (frame_done),
    .frame_err     (frame_err),
    .frame_count   (frame_count)
  );

  always #5 clk_100mhz = ~clk_100mhz;

  // Count single-cycle pulses so each frame can be checked by delta.
  always @(posedge clk_100mhz) begin
    if (frame_done)    done_cnt <= done_cnt + 1;
    if (frame_err)     err_cnt  <= err_cnt + 1;
    if (sample_strobe) strb_cnt <= strb_cnt + 1;
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks = n_checks + 1;
    if (got !== exp) begin
      n_bad = n_bad + 1;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk_100mhz);
  endtask

  // One SPI frame of nbits SCK cycles. MISO is sampled just before each rise.
  // Bits past 16 drive MOSI high. At bit chg_bit ch1_data is switched to 0xAAA.
  task automatic spi_xfer(input logic [15:0] mosi_word, input int nbits, input int chg_bit,
                          output logic [15:0] miso_word, output logic [3:0] extra,
                          output logic oe_mid);
    miso_word = 16'h0000;
    extra     = 4'h0;
    oe_mid    = 1'b0;
    spi_mosi  = mosi_word[15];
    spi_cs_n  = 1'b0;
    wait_cyc(HALF);
    for (int i = 0; i < nbits; i++) begin
      spi_mosi = (i < 16) ? mosi_word[15-i] : 1'b1;
      if (i == chg_bit) ch1_data = 12'hAAA;
      if (i == 0) oe_mid = spi_miso_oe;
      if (i < 16) miso_word[15-i] = spi_miso;
      else if (i < 20) extra[i-16] = spi_miso;
      wait_cyc(1);
      spi_sck = 1'b1;
      wait_cyc(HALF);
      spi_sck = 1'b0;
      wait_cyc(HALF - 1);
    end
    wait_cyc(HALF);
    spi_cs_n = 1'b1;
    spi_mosi = 1'b0;
    wait_cyc(HALF);
  endtask

  logic [15:0] miso_w;
  logic [3:0]  extra_w;
  logic        oe_w;
  int          d0, e0, s0;

  initial begin
    // Reset
    wait_cyc(4);
    rst_n = 1'b1;
    wait_cyc(4);
    check_val("rst_miso", {31'd0, spi_miso}, 32'd0);
    check_val("rst_oe", {31'd0, spi_miso_oe}, 32'd0);
    check_val("rst_count", {16'd0, frame_count}, 32'd0);
    check_val("rst_cur_ch", {30'd0, cur_ch}, 32'd0);

    ch0_data = 12'hABC;
    ch1_data = 12'h555;
    ch2_data = 12'h123;
    ch3_data = 12'hFED;

    // Frame 1: start=1, ch=2 -> returns ch0
    d0 = done_cnt; e0 = err_cnt; s0 = strb_cnt;
    spi_xfer(16'hC000, 16, -1, miso_w, extra_w, oe_w);
    check_val("f1_miso", {16'd0, miso_w}, 32'h0ABC);
    check_val("f1_oe_mid", {31'd0, oe_w}, 32'd1);
    check_val("f1_cur_ch", {30'd0, cur_ch}, 32'd2);
    check_val("f1_count", {16'd0, frame_count}, 32'd1);
    check_val("f1_done", done_cnt - d0, 32'd1);
    check_val("f1_err", err_cnt - e0, 32'd0);
    check_val("f1_strobe", strb_cnt - s0, 32'd1);
    check_val("f1_idle_oe", {31'd0, spi_miso_oe}, 32'd0);
    check_val("f1_idle_miso", {31'd0, spi_miso}, 32'd0);

    // Frame 2: start=1, ch=0 -> returns ch2
    spi_xfer(16'h8000, 16, -1, miso_w, extra_w, oe_w);
    check_val("f2_miso", {16'd0, miso_w}, 32'h8123);
    check_val("f2_cur_ch", {30'd0, cur_ch}, 32'd0);
    check_val("f2_count", {16'd0, frame_count}, 32'd2);

    // Short frame: 10 SCK, command would have selected ch2
    d0 = done_cnt; e0 = err_cnt;
    spi_xfer(16'hC000, 10, -1, miso_w, extra_w, oe_w);
    check_val("short_err", err_cnt - e0, 32'd1);
    check_val("short_done", done_cnt - d0, 32'd0);
    check_val("short_count", {16'd0, frame_count}, 32'd2);
    check_val("short_cur_ch", {30'd0, cur_ch}, 32'd0);

    // Start bit clear: ch field 3 is ignored
    spi_xfer(16'h6000, 16, -1, miso_w, extra_w, oe_w);
    check_val("nostart_miso", {16'd0, miso_w}, 32'h0ABC);
    check_val("nostart_cur_ch", {30'd0, cur_ch}, 32'd0);
    check_val("nostart_count", {16'd0, frame_count}, 32'd3);

    // Overrun: 20 SCK, start=1 ch=1, extra MOSI bits are ones
    d0 = done_cnt; e0 = err_cnt;
    spi_xfer(16'hA000, 20, -1, miso_w, extra_w, oe_w);
    check_val("ovr_miso", {16'd0, miso_w}, 32'h0ABC);
    check_val("ovr_extra", {28'd0, extra_w}, 32'd0);
    check_val("ovr_done", done_cnt - d0, 32'd1);
    check_val("ovr_err", err_cnt - e0, 32'd1);
    check_val("ovr_count", {16'd0, frame_count}, 32'd4);
    check_val("ovr_cur_ch", {30'd0, cur_ch}, 32'd1);

    // Sample hold: ch1 changes to 0xAAA at bit 5, frame still returns 0x555
    spi_xfer(16'h0000, 16, 5, miso_w, extra_w, oe_w);
    check_val("hold_miso", {16'd0, miso_w}, 32'h4555);
    check_val("hold_cur_ch", {30'd0, cur_ch}, 32'd1);
    check_val("hold_count", {16'd0, frame_count}, 32'd5);

    // Reset mid-frame after 8 SCK
    e0 = err_cnt; d0 = done_cnt;
    spi_mosi = 1'b1;
    spi_cs_n = 1'b0;
    wait_cyc(HALF);
    for (int i = 0; i < 8; i++) begin
      spi_sck = 1'b1;
      wait_cyc(HALF);
      spi_sck = 1'b0;
      wait_cyc(HALF);
    end
    rst_n = 1'b0;
    wait_cyc(1);
    check_val("mrst_oe", {31'd0, spi_miso_oe}, 32'd0);
    check_val("mrst_miso", {31'd0, spi_miso}, 32'd0);
    check_val("mrst_count", {16'd0, frame_count}, 32'd0);
    check_val("mrst_cur_ch", {30'd0, cur_ch}, 32'd0);
    spi_cs_n = 1'b1;
    spi_mosi = 1'b0;
    wait_cyc(4);
    rst_n = 1'b1;
    wait_cyc(HALF);
    check_val("mrst_err", err_cnt - e0, 32'd0);
    check_val("mrst_done", done_cnt - d0, 32'd0);
    spi_xfer(16'hC000, 16, -1, miso_w, extra_w, oe_w);
    check_val("post_miso", {16'd0, miso_w}, 32'h0ABC);
    check_val("post_cur_ch", {30'd0, cur_ch}, 32'd2);
    check_val("post_count", {16'd0, frame_count}, 32'd1);

    // Wrap: preload 0xFFFF, one more frame rolls to 0
    @(negedge clk_100mhz);
    force dut.frame_count = 16'hFFFF;
    @(negedge clk_100mhz);
    release dut.frame_count;
    wait_cyc(2);
    check_val("pre_wrap", {16'd0, frame_count}, 32'hFFFF);
    spi_xfer(16'h8000, 16, -1, miso_w, extra_w, oe_w);
    check_val("wrap_miso", {16'd0, miso_w}, 32'h8123);
    check_val("wrap_count", {16'd0, frame_count}, 32'h0000);
    check_val("wrap_cur_ch", {30'd0, cur_ch}, 32'd0);

    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

endmodule
